lap_stopwatch: RTL and testbench

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/lap_stopwatch_pkg.sv | 31 +++
 rtl/lap_stopwatch_bcd_time_counter.sv | 64 ++++++
 rtl/lap_stopwatch.sv | 167 ++++++++++++++++
 tb/tb_lap_stopwatch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_stopwatch_pkg.sv
// lap_stopwatch_pkg
//   Shared definitions for the lap stopwatch: controller state encoding,
//   BCD digit/field limits and the 24-bit mm:ss.cc time layout.
package lap_stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   localparam int unsigned TIME_W = 24;

   // Per-digit limits and the two-digit field limits built from them
   localparam logic [3:0] DIGIT_LIMIT = 4'd9;
   localparam logic [3:0] TENS_LIMIT  = 4'd5;
   localparam logic [7:0] CC_LIMIT    = {DIGIT_LIMIT, DIGIT_LIMIT};   // 99
   localparam logic [7:0] SS_LIMIT    = {TENS_LIMIT, DIGIT_LIMIT};    // 59
   localparam logic [7:0] MM_LIMIT    = {TENS_LIMIT, DIGIT_LIMIT};    // 59

   // Time layout, MSB first: mm_hi mm_lo ss_hi ss_lo cc_hi cc_lo
   typedef struct packed {
      logic [3:0] mm_hi;
      logic [3:0] mm_lo;
      logic [3:0] ss_hi;
      logic [3:0] ss_lo;
      logic [3:0] cc_hi;
      logic [3:0] cc_lo;
   } bcd_time_t;

endpackage

// File: rtl/lap_stopwatch_bcd_time_counter.sv
// bcd_time_counter
//   24-bit BCD mm:ss.cc counter. Advances one hundredth per tick with the
//   full carry ripple resolved in one cycle; rolls 59:59.99 -> 00:00.00.
//   clk    : system clock
//   rst    : asynchronous active-high reset (time -> 00:00.00)
//   clear  : synchronous clear to 00:00.00 (wins over tick)
//   tick   : advance by 10 ms
//   count  : current time, six BCD digits
//   wrap   : high in the cycle a tick rolls the time over
module bcd_time_counter
   import lap_stopwatch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              tick,
   output logic [TIME_W-1:0] count,
   output logic              wrap
);

   bcd_time_t t_q;
   bcd_time_t t_n;

   logic cc_lo_max, ss_lo_max, mm_lo_max;
   logic cc_max, ss_max, mm_max;

   always_comb begin
      cc_lo_max = (t_q.cc_lo == DIGIT_LIMIT);
      ss_lo_max = (t_q.ss_lo == DIGIT_LIMIT);
      mm_lo_max = (t_q.mm_lo == DIGIT_LIMIT);
      cc_max    = ({t_q.cc_hi, t_q.cc_lo} == CC_LIMIT);
      ss_max    = ({t_q.ss_hi, t_q.ss_lo} == SS_LIMIT);
      mm_max    = ({t_q.mm_hi, t_q.mm_lo} == MM_LIMIT);

      t_n = t_q;
      t_n.cc_lo = cc_lo_max ? 4'd0 : t_q.cc_lo + 4'd1;
      if (cc_lo_max)
         t_n.cc_hi = cc_max ? 4'd0 : t_q.cc_hi + 4'd1;
      if (cc_max) begin
         t_n.ss_lo = ss_lo_max ? 4'd0 : t_q.ss_lo + 4'd1;
         if (ss_lo_max)
            t_n.ss_hi = ss_max ? 4'd0 : t_q.ss_hi + 4'd1;
      end
      if (cc_max && ss_max) begin
         t_n.mm_lo = mm_lo_max ? 4'd0 : t_q.mm_lo + 4'd1;
         if (mm_lo_max)
            t_n.mm_hi = mm_max ? 4'd0 : t_q.mm_hi + 4'd1;
      end

      wrap = tick && cc_max && ss_max && mm_max;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         t_q <= '0;
      else if (clear)
         t_q <= '0;
      else if (tick)
         t_q <= t_n;
   end

   assign count = t_q;

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch
//   Stopwatch with 10 ms resolution, lap memory and recall view.
//   clk, rst        : system clock, asynchronous active-high reset
//   start_stop      : IDLE -> RUN (clears time/laps/overflow), RUN/PAUSE -> IDLE
//   pause_resume    : RUN <-> PAUSE (ignored in IDLE, loses to start_stop)
//   record          : store live time as next lap (RUN/PAUSE, not full)
//   recall_toggle   : flip between live and recall view
//   rd_addr         : lap index shown in recall view
//   time_bcd        : registered display value (mm:ss.cc BCD)
//   running, paused : state indicators
//   recall_mode     : 1 = recall view
//   wr_strobe       : one-cycle pulse after each accepted lap write
//   addr_err        : recall view addressing an unwritten lap
//   laps_full       : lap memory full
//   overflow        : sticky, set when time wraps past 59:59.99
//   lap_count       : laps stored, 0..LAP_DEPTH
module lap_stopwatch
   import lap_stopwatch_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 1_000_000,
   parameter int unsigned LAP_DEPTH = 16,
   parameter int unsigned AW        = $clog2(LAP_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_stop,
   input  logic              pause_resume,
   input  logic              record,
   input  logic              recall_toggle,
   input  logic [AW-1:0]     rd_addr,
   output logic [TIME_W-1:0] time_bcd,
   output logic              running,
   output logic              paused,
   output logic              recall_mode,
   output logic              wr_strobe,
   output logic              addr_err,
   output logic              laps_full,
   output logic              overflow,
   output logic [AW:0]       lap_count
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [AW:0]   LAP_FULL  = (AW+1)'(LAP_DEPTH);

   sw_state_t         state;
   logic [PW-1:0]     presc;
   logic              tick;
   logic              start_clear;
   logic              rec_ok;
   logic              wrap;
   logic              rd_err;
   logic [TIME_W-1:0] live_time;
   logic [TIME_W-1:0] lap_mem [LAP_DEPTH];

   // All qualifiers use the pre-edge state, so a record coincident with
   // start_stop from RUN/PAUSE is still accepted.
   assign tick        = (state == ST_RUN) && (presc == PRESC_MAX);
   assign start_clear = (state == ST_IDLE) && start_stop;
   assign laps_full   = (lap_count == LAP_FULL);
   assign rec_ok      = record && (state != ST_IDLE) && !laps_full;
   assign rd_err      = recall_mode && ({1'b0, rd_addr} >= lap_count);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         running <= 1'b0;
         paused  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_stop) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (start_stop) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end else if (pause_resume) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
                  paused  <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (start_stop) begin
                  state  <= ST_IDLE;
                  paused <= 1'b0;
               end else if (pause_resume) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
                  paused  <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
               paused  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc <= '0;
      else if (start_clear)
         presc <= '0;
      else if (state == ST_RUN)
         presc <= tick ? '0 : presc + 1'b1;
   end

   bcd_time_counter u_time (
      .clk   (clk),
      .rst   (rst),
      .clear (start_clear),
      .tick  (tick),
      .count (live_time),
      .wrap  (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_count   <= '0;
         overflow    <= 1'b0;
         wr_strobe   <= 1'b0;
         recall_mode <= 1'b0;
      end else begin
         wr_strobe   <= rec_ok;
         recall_mode <= recall_mode ^ recall_toggle;
         if (start_clear) begin
            lap_count <= '0;
            overflow  <= 1'b0;
         end else begin
            if (rec_ok)
               lap_count <= lap_count + 1'b1;
            if (wrap)
               overflow <= 1'b1;
         end
      end
   end

   // Lap storage: no reset, entries beyond lap_count are never displayed
   always_ff @(posedge clk) begin
      if (rec_ok)
         lap_mem[lap_count[AW-1:0]] <= live_time;
   end

   // Display register doubles as the synchronous read port of lap_mem
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_bcd <= '0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= rd_err;
         if (rd_err)
            time_bcd <= '0;
         else if (recall_mode)
            time_bcd <= lap_mem[rd_addr];
         else
            time_bcd <= live_time;
      end
   end

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch
//   Directed bench for lap_stopwatch with CLK_DIV=4, LAP_DEPTH=4.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_lap_stopwatch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_stop = 1'b0;
   logic        pause_resume = 1'b0;
   logic        record = 1'b0;
   logic        recall_toggle = 1'b0;
   logic [1:0]  rd_addr = '0;
   logic [23:0] time_bcd;
   logic        running, paused, recall_mode, wr_strobe, addr_err;
   logic        laps_full, overflow;
   logic [2:0]  lap_count;

   int n_checks = 0;
   int n_errors = 0;
   int strobe_cnt = 0;
   int strobe_base;

   lap_stopwatch #(.CLK_DIV(4), .LAP_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_stop    (start_stop),
      .pause_resume  (pause_resume),
      .record        (record),
      .recall_toggle (recall_toggle),
      .rd_addr       (rd_addr),
      .time_bcd      (time_bcd),
      .running       (running),
      .paused        (paused),
      .recall_mode   (recall_mode),
      .wr_strobe     (wr_strobe),
      .addr_err      (addr_err),
      .laps_full     (laps_full),
      .overflow      (overflow),
      .lap_count     (lap_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (wr_strobe === 1'b1)
         strobe_cnt <= strobe_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ss;
      start_stop = 1'b1; clocks(1); start_stop = 1'b0;
   endtask

   task automatic pulse_pr;
      pause_resume = 1'b1; clocks(1); pause_resume = 1'b0;
   endtask

   task automatic pulse_rec;
      record = 1'b1; clocks(1); record = 1'b0;
   endtask

   task automatic pulse_tog;
      recall_toggle = 1'b1; clocks(1); recall_toggle = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_time"},    time_bcd,    24'h000000);
      check({tag, "_run"},     running,     1'b0);
      check({tag, "_pause"},   paused,      1'b0);
      check({tag, "_recall"},  recall_mode, 1'b0);
      check({tag, "_strobe"},  wr_strobe,   1'b0);
      check({tag, "_aerr"},    addr_err,    1'b0);
      check({tag, "_count"},   lap_count,   3'd0);
      check({tag, "_full"},    laps_full,   1'b0);
      check({tag, "_ovf"},     overflow,    1'b0);
   endtask

   initial begin
      // reset state
      clocks(2);
      check_reset_outputs("rst0");
      rst = 1'b0;
      clocks(1);

      // idle: pause_resume and record have no effect
      pulse_pr;
      check("idle_pr_run", running, 1'b0);
      check("idle_pr_pause", paused, 1'b0);
      pulse_rec;
      check("idle_rec_strobe", wr_strobe, 1'b0);
      check("idle_rec_count", lap_count, 3'd0);

      // 400 clocks of running: 100 ticks -> 00:01.00
      pulse_ss;
      check("start_run", running, 1'b1);
      clocks(401);
      check("t1s_time", time_bcd, 24'h000100);
      check("t1s_run", running, 1'b1);

      // stop freezes the time
      pulse_ss;
      check("stop_run", running, 1'b0);
      clocks(8);
      check("stop_frozen", time_bcd, 24'h000100);

      // restart clears, pause at 00:00.05 for 40 clocks, resume
      pulse_ss;
      clocks(1);
      check("restart_zero", time_bcd, 24'h000000);
      clocks(20);
      pulse_pr;
      check("pause_flag", paused, 1'b1);
      check("pause_run", running, 1'b0);
      clocks(40);
      check("pause_hold", time_bcd, 24'h000005);
      pulse_pr;
      check("resume_run", running, 1'b1);
      clocks(1);
      check("resume_pre", time_bcd, 24'h000005);
      clocks(2);
      check("resume_inc", time_bcd, 24'h000006);

      // start_stop beats a coincident pause_resume
      start_stop = 1'b1; pause_resume = 1'b1;
      clocks(1);
      start_stop = 1'b0; pause_resume = 1'b0;
      check("both_run", running, 1'b0);
      check("both_pause", paused, 1'b0);

      // two laps, then recall
      pulse_ss;
      clocks(10);
      pulse_rec;
      check("lap0_strobe", wr_strobe, 1'b1);
      check("lap0_count", lap_count, 3'd1);
      clocks(15);
      pulse_rec;
      check("lap1_strobe", wr_strobe, 1'b1);
      check("lap1_count", lap_count, 3'd2);
      clocks(1);
      check("lap1_strobe_end", wr_strobe, 1'b0);
      rd_addr = 2'd1;
      pulse_tog;
      check("recall_on", recall_mode, 1'b1);
      clocks(1);
      check("recall_lap1", time_bcd, 24'h000006);
      check("recall_lap1_aerr", addr_err, 1'b0);
      rd_addr = 2'd0;
      clocks(1);
      check("recall_lap0", time_bcd, 24'h000002);
      rd_addr = 2'd3;
      clocks(1);
      check("recall_a3_aerr", addr_err, 1'b1);
      check("recall_a3_time", time_bcd, 24'h000000);
      rd_addr = 2'd2;
      clocks(1);
      check("recall_a2_aerr", addr_err, 1'b1);
      pulse_tog;
      check("recall_off", recall_mode, 1'b0);
      clocks(1);
      check("recall_off_aerr", addr_err, 1'b0);

      // fill the lap memory: fifth record ignored
      pulse_ss;
      pulse_ss;
      check("refill_clear", lap_count, 3'd0);
      strobe_base = strobe_cnt;
      for (int i = 0; i < 5; i++) begin
         pulse_rec;
         clocks(7);
      end
      check("full_strobes", strobe_cnt - strobe_base, 4);
      check("full_count", lap_count, 3'd4);
      check("full_flag", laps_full, 1'b1);

      // wrap from 59:59.99 while paused, then resume
      pulse_ss;
      pulse_ss;
      check("wrap_start_full", laps_full, 1'b0);
      clocks(21);
      pulse_pr;
      dut.u_time.t_q = 24'h595999;
      clocks(1);
      check("wrap_preset", time_bcd, 24'h595999);
      check("wrap_pre_ovf", overflow, 1'b0);
      pulse_pr;
      clocks(1);
      check("wrap_r1_ovf", overflow, 1'b0);
      clocks(1);
      check("wrap_r2_ovf", overflow, 1'b1);
      clocks(1);
      check("wrap_time", time_bcd, 24'h000000);
      clocks(8);
      check("wrap_continue", time_bcd, 24'h000002);
      pulse_ss;
      check("ovf_sticky_idle", overflow, 1'b1);
      pulse_ss;
      check("ovf_cleared", overflow, 1'b0);

      // asynchronous reset mid-run, mid-write, in recall view
      clocks(5);
      pulse_rec;
      clocks(3);
      pulse_tog;
      pulse_rec;
      check("prerst_count", lap_count, 3'd2);
      check("prerst_strobe", wr_strobe, 1'b1);
      check("prerst_recall", recall_mode, 1'b1);
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      strobe_base = strobe_cnt;
      clocks(2);
      rst = 1'b0;
      clocks(3);
      check("postrst_no_strobe", strobe_cnt - strobe_base, 0);
      check("postrst_idle", running, 1'b0);
      pulse_ss;
      clocks(1);
      check("postrst_time0", time_bcd, 24'h000000);
      check("postrst_run", running, 1'b1);
      clocks(4);
      check("postrst_time1", time_bcd, 24'h000001);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
